axi_burst_arbiter: RTL and testbench

Shares the single AXI-full burst engine inside video_stiching_top between NUM_REQ frame-buffer requesters, for example two CMOS write channels and one video read channel.
- Selects one requester at a time, using round-robin with an urgent override.
- Validates the burst address and hands one command to the engine.
- Waits for the engine to complete the burst, then reports completion to the owner.
- Only one command is ever outstanding; the engine is not pipelined across requesters.

---
 rtl/video_stitching_pkg.sv | 27 ++
 rtl/axi_burst_arbiter_rr_picker.sv | 22 ++
 rtl/axi_burst_arbiter.sv | 119 +++++++++++
 tb/tb_axi_burst_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_stitching_pkg.sv
// video_stitching_pkg: shared types and helpers for the burst arbiter
package video_stitching_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} arb_state_e;

    function automatic int burst_bytes(input int burst_len, input int data_width);
        return burst_len * data_width / 8;
    endfunction

    // First set bit of mask at or after ptr, wrapping modulo n (n <= 8); 0 when mask is empty
    function automatic logic [2:0] rr_select(input logic [7:0] mask, input int n, input int ptr);
        logic [2:0] idx;
        logic       found;
        int         j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = (ptr + k) % n;
            if (k < n && !found && mask[j[2:0]]) begin
                idx   = j[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_burst_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set mask bit from a pointer
module rr_picker
    import video_stitching_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Search upward from the pointer with wrap-around; one-hot grant mirrors the index
    always_comb begin
        idx_o   = IW'(rr_select(8'(mask_i), N, int'(ptr_i)));
        any_o   = |mask_i;
        grant_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/axi_burst_arbiter.sv
// axi_burst_arbiter: shares one AXI burst engine between NUM_REQ requesters
module axi_burst_arbiter
    import video_stitching_pkg::*;
#(
    parameter  int NUM_REQ        = 3,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 128,
    parameter  int BURST_LEN      = 16,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_urgent,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_write,
    output logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    output logic [IW-1:0]                 cmd_owner,
    input  logic                          cmd_done,
    output logic                          busy
);

    localparam int BB = burst_bytes(BURST_LEN, AXI_DATA_WIDTH);
    localparam int OW = $clog2(BB);

    arb_state_e                state_q, state_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      cmd_write_q, cmd_write_d;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [IW-1:0]             cmd_owner_q, cmd_owner_d;
    logic [NUM_REQ-1:0]        urgent_valid, cand, win_oh;
    logic [IW-1:0]             win, next_ptr;
    logic                      win_any, misaligned;
    logic [AXI_ADDR_WIDTH-1:0] win_addr;

    // Urgent requesters, when present, hide everyone else from the picker
    always_comb begin
        urgent_valid = req_valid & req_urgent;
        cand         = |urgent_valid ? urgent_valid : req_valid;
        win_addr     = req_addr[int'(win)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        misaligned   = |win_addr[OW-1:0];
        next_ptr     = (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end

    rr_picker #(.N(NUM_REQ)) u_pick (
        .mask_i  (cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_oh),
        .idx_o   (win),
        .any_o   (win_any)
    );

    // Next-state, command capture and one-cycle requester pulses
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_owner_d = cmd_owner_q;
        req_ack     = '0;
        req_err     = '0;
        req_done    = '0;
        case (state_q)
            IDLE: begin
                // Reset gating keeps the combinational ack quiet while reset is held
                if (win_any && M_AXI_ARESETN) begin
                    req_ack  = win_oh;
                    rr_ptr_d = next_ptr;
                    if (misaligned) begin
                        req_err = win_oh;
                    end else begin
                        state_d     = ISSUE;
                        cmd_write_d = req_write[win];
                        cmd_addr_d  = win_addr;
                        cmd_owner_d = win;
                    end
                end
            end
            ISSUE:     state_d = cmd_ready ? WAIT_DONE : ISSUE;
            WAIT_DONE: begin
                if (cmd_done) begin
                    req_done = NUM_REQ'(1) << cmd_owner_q;
                    state_d  = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // State and command registers
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_owner_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_owner_q <= cmd_owner_d;
        end
    end

    assign cmd_valid = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_owner = cmd_owner_q;

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// tb_axi_burst_arbiter: directed and randomized checks against a rule-level arbiter model
module tb_axi_burst_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0, req_write = '0, req_urgent = '0;
    logic [N*32-1:0] req_addr;
    logic [N-1:0]  req_ack, req_err, req_done;
    logic          cmd_valid, cmd_ready = 1'b0, cmd_write, cmd_done = 1'b0, busy;
    logic [31:0]   cmd_addr;
    logic [1:0]    cmd_owner;
    logic [31:0]   a [N];

    int checks = 0;
    int errors = 0;
    int ptr    = 0;

    always #5 clk = ~clk;
    always_comb req_addr = {a[2], a[1], a[0]};

    axi_burst_arbiter dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_urgent    (req_urgent),
        .req_addr      (req_addr),
        .req_ack       (req_ack),
        .req_err       (req_err),
        .req_done      (req_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_owner     (cmd_owner),
        .cmd_done      (cmd_done),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Winner = candidate with the smallest forward distance from the pointer
    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] u, input int p);
        logic [N-1:0] c;
        int best, bd;
        c    = ((v & u) != 0) ? (v & u) : v;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++)
            if (c[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    // One arbitration decision plus the full engine exchange; starts and ends just after a negedge with the FSM idle
    task automatic round(input int rdy_dly, input int done_dly, input bit noisy, input bit abort);
        int w;
        logic [N-1:0] exp_oh;
        logic mis;
        #1;
        w = pick(req_valid, req_urgent, ptr);
        if (w < 0) begin
            chk("idle_ack", 32'(req_ack), 0);
            @(negedge clk);
            return;
        end
        exp_oh = N'(1) << w;
        mis    = (a[w] % 256) != 0;
        chk("ack", 32'(req_ack), 32'(exp_oh));
        chk("err", 32'(req_err), mis ? 32'(exp_oh) : 0);
        chk("idle_cv", 32'(cmd_valid), 0);
        ptr = (w + 1) % N;
        @(negedge clk);
        req_valid[w] = 1'b0;
        #1;
        if (mis) begin
            chk("rej_cv", 32'(cmd_valid), 0);
            chk("rej_busy", 32'(busy), 0);
            return;
        end
        chk("cv_rise", 32'(cmd_valid), 1);
        chk("owner", 32'(cmd_owner), 32'(w));
        chk("addr", cmd_addr, a[w]);
        chk("write", 32'(cmd_write), 32'(req_write[w]));
        chk("busy_iss", 32'(busy), 1);
        chk("ack_busy", 32'(req_ack), 0);
        for (int i = 0; i < rdy_dly; i++) begin
            cmd_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk("hold_cv", 32'(cmd_valid), 1);
            chk("hold_addr", cmd_addr, a[w]);
            chk("hold_owner", 32'(cmd_owner), 32'(w));
            chk("iss_done", 32'(req_done), 0);
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        cmd_done  = noisy;
        #1;
        chk("hs_cv", 32'(cmd_valid), 1);
        chk("hs_done", 32'(req_done), 0);
        @(negedge clk);
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        #1;
        chk("wait_cv", 32'(cmd_valid), 0);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_owner", 32'(cmd_owner), 32'(w));
        if (abort) return;
        for (int i = 0; i < done_dly; i++) begin
            @(negedge clk);
            if (noisy) req_valid = N'($urandom_range(0, 7));
            #1;
            chk("wait_done0", 32'(req_done), 0);
            chk("wait_ack0", 32'(req_ack), 0);
            chk("wait_busy1", 32'(busy), 1);
        end
        @(negedge clk);
        cmd_done = 1'b1;
        #1;
        chk("done", 32'(req_done), 32'(exp_oh));
        @(negedge clk);
        cmd_done = 1'b0;
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(req_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a[0] = 32'h1000_0000;
        a[1] = 32'h1010_0000;
        a[2] = 32'h1020_0000;
        req_write = 3'b101;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cv", 32'(cmd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_owner", 32'(cmd_owner), 0);
        chk("rst_ack", 32'(req_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Move the pointer to 2 and stall in WAIT_DONE, then reset asynchronously
        req_valid = 3'b001;
        round(0, 2, 0, 0);
        req_valid = 3'b010;
        round(1, 0, 0, 1);
        req_valid = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cv", 32'(cmd_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ack", 32'(req_ack), 0);
        chk("arst_done", 32'(req_done), 0);
        ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Everyone valid, nobody urgent: strict rotation
        for (int r = 0; r < 4; r++) begin
            req_valid = 3'b111;
            round(0, 20, 0, 0);
        end
        // Bring the pointer back to 0, then urgent 1 beats 0
        req_valid = 3'b100;
        round(0, 1, 0, 0);
        req_valid  = 3'b011;
        req_urgent = 3'b010;
        round(0, 2, 0, 0);
        chk("urg_ptr", 32'(ptr), 2);
        round(0, 2, 0, 0);
        chk("urg_then0", 32'(ptr), 1);
        req_urgent = 3'b000;
        // Misaligned read from requester 2 is rejected and moves the pointer past it
        a[2]         = 32'h1000_0040;
        req_write[2] = 1'b0;
        req_valid    = 3'b100;
        round(0, 0, 0, 0);
        chk("rej_ptr", 32'(ptr), 0);
        a[2]      = 32'h1020_0000;
        req_valid = 3'b011;
        round(0, 1, 0, 0);
        req_valid = 3'b000;
        // Long backpressure on cmd_ready
        req_valid = 3'b010;
        round(10, 3, 0, 0);
        // Spurious cmd_done while idle
        req_valid = 3'b000;
        cmd_done  = 1'b1;
        #1;
        chk("spur_idle_done", 32'(req_done), 0);
        chk("spur_idle_busy", 32'(busy), 0);
        @(negedge clk);
        cmd_done = 1'b0;
        #1;
        chk("spur_idle_cv", 32'(cmd_valid), 0);
        // Spurious cmd_done during ISSUE and on the handshake
        req_valid = 3'b001;
        round(4, 3, 1, 0);
        // Randomized traffic with withdrawals, urgency and occasional misalignment
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    a[i] = ($urandom & 32'hFFFF_FF00) | (($urandom_range(0, 4) == 0) ? 32'h40 : 32'h0);
                    req_write[i] = 1'($urandom_range(0, 1));
                end
            end
            req_valid  = N'($urandom_range(0, 7));
            req_urgent = N'($urandom_range(0, 7));
            round($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
